// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler sharing one spi_master between NUM_REQ requesters.
// Grants one requester at a time, applies its SPI mode, streams its burst into
// the master TX FIFO, kicks the master and waits for the burst to drain.
module spi_txn_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [2*NUM_REQ-1:0]          req_mode_i,
    input  logic [LEN_WIDTH*NUM_REQ-1:0]  req_len_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            data_rd_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic                          spi_cpol_o,
    output logic                          spi_cpha_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_empty_i,
    output logic                          spi_start_o,
    input  logic                          spi_busy_i
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Gap counter holds GAP_CYCLES-1 down to 0
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StArm, StWait, StDone, StGap
    } state_e;

    state_e                 state_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [NUM_REQ-1:0]     done_q;
    logic [IdxW-1:0]        gidx_q;
    logic [IdxW-1:0]        ptr_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic [GapW-1:0]        gap_cnt_q;
    logic                   cpol_q;
    logic                   cpha_q;
    logic                   start_q;

    logic [1:0]             mode_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0]   len_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];

    logic                   pick_valid;
    logic [IdxW-1:0]        pick_idx;
    logic [IdxW-1:0]        cand;
    logic                   load_wr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign mode_arr[i] = req_mode_i[2*i +: 2];
        assign len_arr[i]  = req_len_i[LEN_WIDTH*i +: LEN_WIDTH];
        assign data_arr[i] = req_data_i[DATA_WIDTH*i +: DATA_WIDTH];
    end

    // Round-robin pick: first requesting index at or after the pointer, wrapping
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % NUM_REQ);
            if (!pick_valid && req_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // FIFO write path is combinational so fifo_full stalls without losing a byte
    always_comb begin
        load_wr        = (state_q == StLoad) && !fifo_full_i;
        fifo_wr_en_o   = load_wr;
        data_rd_o      = load_wr ? grant_q : '0;
        fifo_wr_data_o = (state_q == StLoad) ? data_arr[gidx_q] : '0;
    end

    // Scheduler FSM with registered grant, mode, start and done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            done_q    <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gap_cnt_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            done_q  <= '0;
            start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        gidx_q  <= pick_idx;
                        grant_q <= NUM_REQ'(1) << pick_idx;
                        cpol_q  <= mode_arr[pick_idx][1];
                        cpha_q  <= mode_arr[pick_idx][0];
                        cnt_q   <= len_arr[pick_idx];
                        state_q <= (len_arr[pick_idx] == '0) ? StDone : StLoad;
                    end
                end
                StLoad: begin
                    if (!fifo_full_i) begin
                        cnt_q <= cnt_q - LEN_WIDTH'(1);
                        if (cnt_q == LEN_WIDTH'(1)) begin
                            state_q <= StStart;
                            start_q <= 1'b1;
                        end
                    end
                end
                StStart: state_q <= StArm;
                // Blanking cycle: the master may not have raised busy yet
                StArm:   state_q <= StWait;
                StWait: begin
                    if (!spi_busy_i) begin
                        if (fifo_empty_i) begin
                            state_q <= StDone;
                        end else begin
                            // Master that sends one byte per start needs another kick
                            state_q <= StStart;
                            start_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    done_q    <= grant_q;
                    grant_q   <= '0;
                    ptr_q     <= (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + IdxW'(1);
                    gap_cnt_q <= GapLoad;
                    state_q   <= (GAP_CYCLES == 0) ? StIdle : StGap;
                end
                StGap: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GapW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign spi_cpol_o  = cpol_q;
    assign spi_cpha_o  = cpha_q;
    assign spi_start_o = start_q;

endmodule
